mc14500_wide: RTL and testbench
===============================

# mc14500_wide

Parametrised successor to the 1-bit MC14500 industrial control unit. It executes the same 16-opcode instruction set on a WIDTH-bit result register. It adds an internal program counter, an internal call/return stack, a run-enable, and registered I/O strobes, so no external PC or JSR logic is needed. It sits between a program ROM (asynchronous read) and an addressed I/O bus in the multi-project top.

## Interface
- WIDTH, 8: width of RR, DATA_IN and DATA_OUT.
- OPND_W, 8: operand width; also the PC width.
- ADDR_W, 4: I/O address width, 1 ≤ ADDR_W ≤ OPND_W.
- STACK_DEPTH, 4: return-stack entries, ≥ 2.
- X2  in  1: clock; all state updates on the rising edge.
- RST_N  in  1: asynchronous active-low reset.
- EN  in  1: run enable; low freezes all state and forces every pulse output low.
- PROG_ADDR  out  OPND_W: current PC, registered.
- PROG_DATA  in  4+OPND_W: {opcode[3:0], operand}; sampled in the same cycle.
- IO_ADDR  out  ADDR_W: combinational operand[ADDR_W-1:0] of the current instruction.
- DATA_IN  in  WIDTH: read data for IO_ADDR, sampled at the rising edge.
- DATA_OUT  out  WIDTH: last stored value, registered.
- WR_ADDR  out  ADDR_W: address of the last store, registered.
- WRITE  out  1: one-cycle write strobe.
- RR  out  WIDTH: result register.
- FLAG_O, FLAG_F, JMP_O, RTN_O  out  1: one-cycle registered pulses.
- STK_ERR  out  1: sticky stack overflow/underflow; cleared only by reset.

## Operation
- Opcodes, where D = IEN ? DATA_IN : 0:
  - 0 NOPO: pulses FLAG_O.
  - 1 LD: RR=D.
  - 2 LDC: RR=~D.
  - 3 AND: RR=RR&D.
  - 4 ANDC: RR=RR&~D.
  - 5 OR: RR=RR|D.
  - 6 ORC: RR=RR|~D.
  - 7 XNOR: RR=~(RR^D).
  - 8 STO: stores RR.
  - 9 STOC: stores ~RR.
  - A IEN: IEN=DATA_IN[0], using the raw input, not D.
  - B OEN: OEN=DATA_IN[0], using the raw input.
  - C JMP: call.
  - D RTN: return.
  - E SKZ: skip next instruction.
  - F NOPF: pulses FLAG_F.
- STO/STOC:
  - If OEN=1: DATA_OUT=value, WR_ADDR=IO_ADDR, and WRITE pulses.
  - If OEN=0: DATA_OUT, WR_ADDR and WRITE are unchanged or low.
- JMP:
  - Pushes (PC+1) mod 2^OPND_W and sets PC=operand. JMP_O pulses.
  - A plain goto is a JMP whose return is never popped.
- RTN: pops the top entry into PC. RTN_O pulses. RTN never skips the following instruction.
- SKZ: sets skip if RR==0 (all bits, value before this cycle).
- Skip:
  - The next fetched instruction is suppressed: no RR/IEN/OEN/stack/PC-target change and no pulses.
  - PC still increments, and skip then clears. A suppressed SKZ does not re-arm skip.
- PC: increments by 1 unless JMP/RTN. It wraps from 2^OPND_W-1 to 0.
- Stack: circular buffer with an occupancy count 0..STACK_DEPTH.
  - Push while full overwrites the oldest entry; count stays at STACK_DEPTH and STK_ERR is set.
  - Pop while empty loads PC=0 and sets STK_ERR.
- Reset values:
  - PC=0, RR=0, IEN=0, OEN=0, skip=0, stack empty.
  - DATA_OUT=0, WR_ADDR=0, all pulses 0, STK_ERR=0.

## Timing
- One instruction per enabled cycle.
- Fetch and execute in cycle n: PROG_ADDR=PC(n), and the decode of PROG_DATA/DATA_IN is registered at the edge ending n.
- Pulse outputs for an instruction in cycle n are high during cycle n+1 only, and coincide with the new DATA_OUT.
- Branch latency 0: the instruction at the target executes in cycle n+1, with no delay slot.
- EN low in cycle n: nothing updates at the edge; pulses are low in n+1.
  - Skip survives an EN-low cycle and suppresses the next enabled instruction.
- RST_N low at any time clears state immediately, including mid-skip or with a full stack. The first fetch after release is address 0.
- Simultaneous events: JMP with a full stack both jumps and sets STK_ERR in the same edge.

## Structure
- Package mc14500w_pkg holds:
  - Opcode localparams OP_NOPO..OP_NOPF.
  - Function clog2_min1 (minimum 1) for pointer widths.
- Sub-module mc14500w_stack:
  - Parameters DEPTH and W.
  - Ports push, pop (mutually exclusive), din, dout (top of stack), full, empty, err_pulse.
  - Same clock and asynchronous reset as the top.
- Top contains the decode, the logic unit (a case on opcode), and the PC/skip/IEN/OEN registers.

## Test plan
- Reset then run with default parameters:
  - Program LD, OEN(DATA_IN=1) then STO to addr 3, with DATA_IN=0xA5 and IEN=1.
  - Required: WRITE pulses in the cycle after STO, WR_ADDR=3, DATA_OUT=0xA5.
- IEN=0 then LDC: RR=0xFF.
  - Then OEN with DATA_IN[0]=0, then STO: no WRITE, and DATA_OUT keeps its prior value.
- RR=0, SKZ, then JMP 0x40: the JMP is suppressed, PC continues sequentially, and JMP_O stays low.
  - Repeat with RR=0x01: the JMP is taken, and PROG_ADDR=0x40 in the following cycle.
- Nested calls, STACK_DEPTH=4:
  - 5 JMPs without return: STK_ERR=1 after the 5th.
  - 4 RTNs then return to the 4 most recent return addresses.
  - A 5th RTN: PC=0.
- PC at 0xFF executing NOPF: PC wraps to 0x00, and FLAG_F is high for exactly one cycle.
- Mid-operation events:
  - RST_N asserted while skip=1 and stack=3 deep: all outputs are at their reset values immediately.
  - EN held low for 3 cycles: PC and RR are frozen and all pulses are low.

Source files
------------

// File: rtl/mc14500w_pkg.sv
// Shared opcode encodings and sizing helper for the wide MC14500 control unit.
package mc14500w_pkg;

  localparam logic [3:0] OP_NOPO = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_LDC  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_ANDC = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_ORC  = 4'h6;
  localparam logic [3:0] OP_XNOR = 4'h7;
  localparam logic [3:0] OP_STO  = 4'h8;
  localparam logic [3:0] OP_STOC = 4'h9;
  localparam logic [3:0] OP_IEN  = 4'hA;
  localparam logic [3:0] OP_OEN  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RTN  = 4'hD;
  localparam logic [3:0] OP_SKZ  = 4'hE;
  localparam logic [3:0] OP_NOPF = 4'hF;

  // ceil(log2(n)), never less than 1 so a single-entry structure still gets a bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mc14500w_stack.sv
// Circular return-address stack: push while full drops the oldest entry,
// pop while empty is reported; both raise err_pulse for one cycle.
module mc14500w_stack
  import mc14500w_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         err_pulse
);

  localparam int PW = clog2_min1(DEPTH);
  localparam int CW = clog2_min1(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_ptr;   // next slot to write
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] w_top;
  logic [PW-1:0] w_ptr_inc;

  assign w_top     = (r_ptr == '0) ? PW'(DEPTH - 1) : r_ptr - 1'b1;
  assign w_ptr_inc = (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
  assign dout      = r_mem[w_top];
  assign full      = (r_cnt == CW'(DEPTH));
  assign empty     = (r_cnt == '0);
  assign err_pulse = (push & full) | (pop & empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (push) begin
      r_mem[r_ptr] <= din;
      r_ptr        <= w_ptr_inc;
      if (!full) r_cnt <= r_cnt + 1'b1;
    end else if (pop && !empty) begin
      r_ptr <= w_top;
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/mc14500_wide.sv
// WIDTH-bit MC14500-compatible control unit with internal PC, return stack,
// run enable and registered I/O strobes; one instruction per enabled cycle.
module mc14500_wide
  import mc14500w_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int OPND_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic              X2,
  input  logic              RST_N,
  input  logic              EN,
  output logic [OPND_W-1:0] PROG_ADDR,
  input  logic [OPND_W+3:0] PROG_DATA,
  output logic [ADDR_W-1:0] IO_ADDR,
  input  logic [WIDTH-1:0]  DATA_IN,
  output logic [WIDTH-1:0]  DATA_OUT,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic              WRITE,
  output logic [WIDTH-1:0]  RR,
  output logic              FLAG_O,
  output logic              FLAG_F,
  output logic              JMP_O,
  output logic              RTN_O,
  output logic              STK_ERR
);

  logic [OPND_W-1:0] r_pc;
  logic [WIDTH-1:0]  r_rr;
  logic              r_ien;
  logic              r_oen;
  logic              r_skip;
  logic [WIDTH-1:0]  r_dout;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_write;
  logic              r_flag_o;
  logic              r_flag_f;
  logic              r_jmp;
  logic              r_rtn;
  logic              r_stk_err;

  logic [3:0]        w_op;
  logic [OPND_W-1:0] w_opnd;
  logic [WIDTH-1:0]  w_d;
  logic              w_exec;
  logic [WIDTH-1:0]  w_rr_nxt;
  logic [WIDTH-1:0]  w_st_val;
  logic              w_store;
  logic              w_ld_ien;
  logic              w_ld_oen;
  logic              w_call;
  logic              w_ret;
  logic              w_skz;
  logic              w_nopo;
  logic              w_nopf;
  logic              w_push;
  logic              w_pop;
  logic [OPND_W-1:0] w_pc_inc;
  logic [OPND_W-1:0] w_pc_nxt;
  logic [OPND_W-1:0] w_stk_top;
  logic              w_stk_full;
  logic              w_stk_empty;
  logic              w_stk_err;

  assign w_op     = PROG_DATA[OPND_W+3:OPND_W];
  assign w_opnd   = PROG_DATA[OPND_W-1:0];
  assign IO_ADDR  = w_opnd[ADDR_W-1:0];
  assign w_d      = r_ien ? DATA_IN : '0;
  // A pending skip swallows exactly one enabled instruction.
  assign w_exec   = EN & ~r_skip;
  assign w_push   = w_exec & w_call;
  assign w_pop    = w_exec & w_ret;
  assign w_pc_inc = r_pc + 1'b1;

  always_comb begin
    w_rr_nxt = r_rr;
    w_st_val = r_rr;
    w_store  = 1'b0;
    w_ld_ien = 1'b0;
    w_ld_oen = 1'b0;
    w_call   = 1'b0;
    w_ret    = 1'b0;
    w_skz    = 1'b0;
    w_nopo   = 1'b0;
    w_nopf   = 1'b0;
    case (w_op)
      OP_NOPO: w_nopo = 1'b1;
      OP_LD:   w_rr_nxt = w_d;
      OP_LDC:  w_rr_nxt = ~w_d;
      OP_AND:  w_rr_nxt = r_rr & w_d;
      OP_ANDC: w_rr_nxt = r_rr & ~w_d;
      OP_OR:   w_rr_nxt = r_rr | w_d;
      OP_ORC:  w_rr_nxt = r_rr | ~w_d;
      OP_XNOR: w_rr_nxt = ~(r_rr ^ w_d);
      OP_STO:  w_store = 1'b1;
      OP_STOC: begin
        w_store  = 1'b1;
        w_st_val = ~r_rr;
      end
      OP_IEN:  w_ld_ien = 1'b1;
      OP_OEN:  w_ld_oen = 1'b1;
      OP_JMP:  w_call = 1'b1;
      OP_RTN:  w_ret = 1'b1;
      OP_SKZ:  w_skz = 1'b1;
      OP_NOPF: w_nopf = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_pc_nxt = w_pc_inc;
    if (w_push)     w_pc_nxt = w_opnd;
    else if (w_pop) w_pc_nxt = w_stk_empty ? '0 : w_stk_top;
  end

  mc14500w_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (OPND_W)
  ) u_stack (
    .clk       (X2),
    .rst_n     (RST_N),
    .push      (w_push),
    .pop       (w_pop),
    .din       (w_pc_inc),
    .dout      (w_stk_top),
    .full      (w_stk_full),
    .empty     (w_stk_empty),
    .err_pulse (w_stk_err)
  );

  always_ff @(posedge X2 or negedge RST_N) begin
    if (!RST_N) begin
      r_pc      <= '0;
      r_rr      <= '0;
      r_ien     <= 1'b0;
      r_oen     <= 1'b0;
      r_skip    <= 1'b0;
      r_dout    <= '0;
      r_wr_addr <= '0;
      r_write   <= 1'b0;
      r_flag_o  <= 1'b0;
      r_flag_f  <= 1'b0;
      r_jmp     <= 1'b0;
      r_rtn     <= 1'b0;
      r_stk_err <= 1'b0;
    end else begin
      r_write  <= w_exec & w_store & r_oen;
      r_flag_o <= w_exec & w_nopo;
      r_flag_f <= w_exec & w_nopf;
      r_jmp    <= w_push;
      r_rtn    <= w_pop;
      if (w_stk_err) r_stk_err <= 1'b1;
      if (EN) begin
        r_pc   <= w_pc_nxt;
        r_skip <= w_exec & w_skz & (r_rr == '0);
      end
      if (w_exec) begin
        r_rr <= w_rr_nxt;
        if (w_ld_ien) r_ien <= DATA_IN[0];
        if (w_ld_oen) r_oen <= DATA_IN[0];
        if (w_store && r_oen) begin
          r_dout    <= w_st_val;
          r_wr_addr <= IO_ADDR;
        end
      end
    end
  end

  assign PROG_ADDR = r_pc;
  assign RR        = r_rr;
  assign DATA_OUT  = r_dout;
  assign WR_ADDR   = r_wr_addr;
  assign STK_ERR   = r_stk_err;
  // Pulses are held low for the whole of any stalled cycle.
  assign WRITE     = r_write & EN;
  assign FLAG_O    = r_flag_o & EN;
  assign FLAG_F    = r_flag_f & EN;
  assign JMP_O     = r_jmp & EN;
  assign RTN_O     = r_rtn & EN;

endmodule

// File: tb/tb_mc14500_wide.sv
// Table-driven bench for mc14500_wide: each row is one instruction cycle plus
// the outputs expected after its edge, checked through an expected queue.
module tb_mc14500_wide;
  import mc14500w_pkg::*;

  localparam int SBW = 34;
  localparam logic [4:0] P_N = 5'b00000;
  localparam logic [4:0] P_W = 5'b10000;
  localparam logic [4:0] P_O = 5'b01000;
  localparam logic [4:0] P_F = 5'b00100;
  localparam logic [4:0] P_J = 5'b00010;
  localparam logic [4:0] P_R = 5'b00001;

  logic        X2 = 1'b0;
  logic        RST_N;
  logic        EN;
  logic [7:0]  PROG_ADDR;
  logic [11:0] PROG_DATA;
  logic [3:0]  IO_ADDR;
  logic [7:0]  DATA_IN;
  logic [7:0]  DATA_OUT;
  logic [3:0]  WR_ADDR;
  logic        WRITE;
  logic [7:0]  RR;
  logic        FLAG_O, FLAG_F, JMP_O, RTN_O, STK_ERR;

  mc14500_wide #(
    .WIDTH(8), .OPND_W(8), .ADDR_W(4), .STACK_DEPTH(4)
  ) dut (
    .X2(X2), .RST_N(RST_N), .EN(EN), .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA),
    .IO_ADDR(IO_ADDR), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .WR_ADDR(WR_ADDR),
    .WRITE(WRITE), .RR(RR), .FLAG_O(FLAG_O), .FLAG_F(FLAG_F), .JMP_O(JMP_O),
    .RTN_O(RTN_O), .STK_ERR(STK_ERR)
  );

  // clock / reset
  always #5 X2 = ~X2;

  typedef struct {
    logic           en;
    logic [3:0]     op;
    logic [7:0]     opnd;
    logic [7:0]     din;
    logic [SBW-1:0] exp;
  } vec_t;

  vec_t           vecs[$];
  logic [SBW-1:0] exp_q[$];
  string          name_q[$];
  int             n_checks = 0;
  int             n_errors = 0;

  function automatic logic [SBW-1:0] pack_exp(input logic [7:0] pc, input logic [7:0] rr,
                                              input logic [7:0] dout, input logic [3:0] wa,
                                              input logic [4:0] pls, input logic err);
    return {pc, rr, dout, wa, pls, err};
  endfunction

  function automatic vec_t mk(input logic en, input logic [3:0] op, input logic [7:0] opnd,
                              input logic [7:0] din, input logic [7:0] pc, input logic [7:0] rr,
                              input logic [7:0] dout, input logic [3:0] wa,
                              input logic [4:0] pls, input logic err);
    vec_t v;
    v.en   = en;
    v.op   = op;
    v.opnd = opnd;
    v.din  = din;
    v.exp  = pack_exp(pc, rr, dout, wa, pls, err);
    return v;
  endfunction

  // scoreboard
  task automatic compare(input string name, input logic [SBW-1:0] exp);
    logic [SBW-1:0] act;
    act = {PROG_ADDR, RR, DATA_OUT, WR_ADDR, WRITE, FLAG_O, FLAG_F, JMP_O, RTN_O, STK_ERR};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got pc=%h rr=%h dout=%h wa=%h pls=%b err=%b, expected pc=%h rr=%h dout=%h wa=%h pls=%b err=%b",
               name, act[33:26], act[25:18], act[17:10], act[9:6], act[5:1], act[0],
               exp[33:26], exp[25:18], exp[17:10], exp[9:6], exp[5:1], exp[0]);
    end
  endtask

  task automatic sb_pop();
    while (exp_q.size() > 0) compare(name_q.pop_front(), exp_q.pop_front());
  endtask

  // driver
  task automatic step(input string name, input vec_t v);
    @(negedge X2);
    sb_pop();
    EN        = v.en;
    PROG_DATA = {v.op, v.opnd};
    DATA_IN   = v.din;
    exp_q.push_back(v.exp);
    name_q.push_back(name);
  endtask

  task automatic drain();
    @(negedge X2);
    sb_pop();
  endtask

  initial begin
    RST_N     = 1'b0;
    EN        = 1'b0;
    PROG_DATA = '0;
    DATA_IN   = '0;

    // basic store path with IEN/OEN enabled
    vecs.push_back(mk(1, OP_IEN,  8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 4'h0, P_N, 0));
    vecs.push_back(mk(1, OP_LD,   8'h00, 8'hA5, 8'h02, 8'hA5, 8'h00, 4'h0, P_N, 0));
    vecs.push_back(mk(1, OP_OEN,  8'h00, 8'h01, 8'h03, 8'hA5, 8'h00, 4'h0, P_N, 0));
    vecs.push_back(mk(1, OP_STO,  8'h03, 8'h00, 8'h04, 8'hA5, 8'hA5, 4'h3, P_W, 0));
    vecs.push_back(mk(1, OP_NOPO, 8'h00, 8'h00, 8'h05, 8'hA5, 8'hA5, 4'h3, P_O, 0));
    // input/output disabled
    vecs.push_back(mk(1, OP_IEN,  8'h00, 8'h00, 8'h06, 8'hA5, 8'hA5, 4'h3, P_N, 0));
    vecs.push_back(mk(1, OP_LDC,  8'h00, 8'h3C, 8'h07, 8'hFF, 8'hA5, 4'h3, P_N, 0));
    vecs.push_back(mk(1, OP_OEN,  8'h00, 8'hFE, 8'h08, 8'hFF, 8'hA5, 4'h3, P_N, 0));
    vecs.push_back(mk(1, OP_STO,  8'h05, 8'h00, 8'h09, 8'hFF, 8'hA5, 4'h3, P_N, 0));
    vecs.push_back(mk(1, OP_STOC, 8'h05, 8'h00, 8'h0A, 8'hFF, 8'hA5, 4'h3, P_N, 0));
    // logic unit
    vecs.push_back(mk(1, OP_IEN,  8'h00, 8'h01, 8'h0B, 8'hFF, 8'hA5, 4'h3, P_N, 0));
    vecs.push_back(mk(1, OP_AND,  8'h00, 8'h0F, 8'h0C, 8'h0F, 8'hA5, 4'h3, P_N, 0));
    vecs.push_back(mk(1, OP_OR,   8'h00, 8'h30, 8'h0D, 8'h3F, 8'hA5, 4'h3, P_N, 0));
    vecs.push_back(mk(1, OP_XNOR, 8'h00, 8'h0F, 8'h0E, 8'hCF, 8'hA5, 4'h3, P_N, 0));
    vecs.push_back(mk(1, OP_ANDC, 8'h00, 8'h03, 8'h0F, 8'hCC, 8'hA5, 4'h3, P_N, 0));
    vecs.push_back(mk(1, OP_ORC,  8'h00, 8'hFE, 8'h10, 8'hCD, 8'hA5, 4'h3, P_N, 0));
    vecs.push_back(mk(1, OP_OEN,  8'h00, 8'h01, 8'h11, 8'hCD, 8'hA5, 4'h3, P_N, 0));
    vecs.push_back(mk(1, OP_STOC, 8'h27, 8'h00, 8'h12, 8'hCD, 8'h32, 4'h7, P_W, 0));
    // skip taken, then skip not taken
    vecs.push_back(mk(1, OP_LD,   8'h00, 8'h00, 8'h13, 8'h00, 8'h32, 4'h7, P_N, 0));
    vecs.push_back(mk(1, OP_SKZ,  8'h00, 8'h00, 8'h14, 8'h00, 8'h32, 4'h7, P_N, 0));
    vecs.push_back(mk(1, OP_JMP,  8'h40, 8'h00, 8'h15, 8'h00, 8'h32, 4'h7, P_N, 0));
    vecs.push_back(mk(1, OP_NOPF, 8'h00, 8'h00, 8'h16, 8'h00, 8'h32, 4'h7, P_F, 0));
    vecs.push_back(mk(1, OP_LD,   8'h00, 8'h01, 8'h17, 8'h01, 8'h32, 4'h7, P_N, 0));
    vecs.push_back(mk(1, OP_SKZ,  8'h00, 8'h00, 8'h18, 8'h01, 8'h32, 4'h7, P_N, 0));
    vecs.push_back(mk(1, OP_JMP,  8'h40, 8'h00, 8'h40, 8'h01, 8'h32, 4'h7, P_J, 0));
    vecs.push_back(mk(1, OP_RTN,  8'h00, 8'h00, 8'h19, 8'h01, 8'h32, 4'h7, P_R, 0));
    // a suppressed SKZ does not re-arm
    vecs.push_back(mk(1, OP_LD,   8'h00, 8'h00, 8'h1A, 8'h00, 8'h32, 4'h7, P_N, 0));
    vecs.push_back(mk(1, OP_SKZ,  8'h00, 8'h00, 8'h1B, 8'h00, 8'h32, 4'h7, P_N, 0));
    vecs.push_back(mk(1, OP_SKZ,  8'h00, 8'h00, 8'h1C, 8'h00, 8'h32, 4'h7, P_N, 0));
    vecs.push_back(mk(1, OP_NOPO, 8'h00, 8'h00, 8'h1D, 8'h00, 8'h32, 4'h7, P_O, 0));
    // five nested calls overflow a four-deep stack
    vecs.push_back(mk(1, OP_JMP,  8'h50, 8'h00, 8'h50, 8'h00, 8'h32, 4'h7, P_J, 0));
    vecs.push_back(mk(1, OP_JMP,  8'h60, 8'h00, 8'h60, 8'h00, 8'h32, 4'h7, P_J, 0));
    vecs.push_back(mk(1, OP_JMP,  8'h70, 8'h00, 8'h70, 8'h00, 8'h32, 4'h7, P_J, 0));
    vecs.push_back(mk(1, OP_JMP,  8'h80, 8'h00, 8'h80, 8'h00, 8'h32, 4'h7, P_J, 0));
    vecs.push_back(mk(1, OP_JMP,  8'h90, 8'h00, 8'h90, 8'h00, 8'h32, 4'h7, P_J, 1));
    vecs.push_back(mk(1, OP_RTN,  8'h00, 8'h00, 8'h81, 8'h00, 8'h32, 4'h7, P_R, 1));
    vecs.push_back(mk(1, OP_RTN,  8'h00, 8'h00, 8'h71, 8'h00, 8'h32, 4'h7, P_R, 1));
    vecs.push_back(mk(1, OP_RTN,  8'h00, 8'h00, 8'h61, 8'h00, 8'h32, 4'h7, P_R, 1));
    vecs.push_back(mk(1, OP_RTN,  8'h00, 8'h00, 8'h51, 8'h00, 8'h32, 4'h7, P_R, 1));
    vecs.push_back(mk(1, OP_RTN,  8'h00, 8'h00, 8'h00, 8'h00, 8'h32, 4'h7, P_R, 1));
    // PC wrap at 0xFF
    vecs.push_back(mk(1, OP_JMP,  8'hFF, 8'h00, 8'hFF, 8'h00, 8'h32, 4'h7, P_J, 1));
    vecs.push_back(mk(1, OP_NOPF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h32, 4'h7, P_F, 1));
    vecs.push_back(mk(1, OP_NOPO, 8'h00, 8'h00, 8'h01, 8'h00, 8'h32, 4'h7, P_O, 1));
    // run enable low for three cycles
    vecs.push_back(mk(1, OP_LD,   8'h00, 8'h5A, 8'h02, 8'h5A, 8'h32, 4'h7, P_N, 1));
    vecs.push_back(mk(0, OP_NOPO, 8'h00, 8'h00, 8'h02, 8'h5A, 8'h32, 4'h7, P_N, 1));
    vecs.push_back(mk(0, OP_JMP,  8'h33, 8'h00, 8'h02, 8'h5A, 8'h32, 4'h7, P_N, 1));
    vecs.push_back(mk(0, OP_STO,  8'h0C, 8'h00, 8'h02, 8'h5A, 8'h32, 4'h7, P_N, 1));
    vecs.push_back(mk(1, OP_NOPF, 8'h00, 8'h00, 8'h03, 8'h5A, 8'h32, 4'h7, P_F, 1));
    // skip survives an EN-low cycle
    vecs.push_back(mk(1, OP_LD,   8'h00, 8'h00, 8'h04, 8'h00, 8'h32, 4'h7, P_N, 1));
    vecs.push_back(mk(1, OP_SKZ,  8'h00, 8'h00, 8'h05, 8'h00, 8'h32, 4'h7, P_N, 1));
    vecs.push_back(mk(0, OP_NOPO, 8'h00, 8'h00, 8'h05, 8'h00, 8'h32, 4'h7, P_N, 1));
    vecs.push_back(mk(1, OP_NOPF, 8'h00, 8'h00, 8'h06, 8'h00, 8'h32, 4'h7, P_N, 1));
    vecs.push_back(mk(1, OP_NOPF, 8'h00, 8'h00, 8'h07, 8'h00, 8'h32, 4'h7, P_F, 1));

    repeat (2) @(negedge X2);
    compare("reset_state", pack_exp(8'h00, 8'h00, 8'h00, 4'h0, P_N, 1'b0));
    RST_N = 1'b1;

    foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);

    // stack three deep with skip armed, then asynchronous reset mid-cycle
    step("hs_call1", mk(1, OP_JMP, 8'h10, 8'h00, 8'h10, 8'h00, 8'h32, 4'h7, P_J, 1));
    step("hs_call2", mk(1, OP_JMP, 8'h20, 8'h00, 8'h20, 8'h00, 8'h32, 4'h7, P_J, 1));
    step("hs_ld0",   mk(1, OP_LD,  8'h00, 8'h00, 8'h21, 8'h00, 8'h32, 4'h7, P_N, 1));
    step("hs_skz",   mk(1, OP_SKZ, 8'h00, 8'h00, 8'h22, 8'h00, 8'h32, 4'h7, P_N, 1));
    drain();
    PROG_DATA = {OP_NOPO, 8'h00};
    #2 RST_N = 1'b0;
    #1 compare("async_reset", pack_exp(8'h00, 8'h00, 8'h00, 4'h0, P_N, 1'b0));
    @(negedge X2);
    compare("reset_hold", pack_exp(8'h00, 8'h00, 8'h00, 4'h0, P_N, 1'b0));
    EN    = 1'b0;
    RST_N = 1'b1;
    step("post_rst_nopo", mk(1, OP_NOPO, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 4'h0, P_O, 0));
    step("post_rst_rtn",  mk(1, OP_RTN,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, P_R, 1));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
